// File: rtl/dram_device_model_if.sv
`default_nettype none
// ============================================================================
// Module      : dram_device_model_if
// Description : Command/data bundle between a DRAM controller and the
//               dram_device_model single-bank device.
//   DRAM_CSn    chip select, active low (CSn=1 is a NOP cycle)
//   DRAM_RASn   row strobe, active low
//   DRAM_CASn   column strobe, active low
//   DRAM_WEn    per-byte write enable, active low (4 bits)
//   DRAM_A      row address on ACT, column address on READ/WRITE (11 bits)
//   DRAM_D      write data (32 bits)
//   DRAM_Q      read data, zero whenever DRAM_valid is low (32 bits)
//   DRAM_valid  one-cycle strobe qualifying DRAM_Q
//   DRAM_err    sticky protocol/timing error flag
//   Modports: master = controller side, slave = device side.
// Revision    : 1.0 - initial release
// ============================================================================
interface dram_device_model_if;
   logic        DRAM_CSn;
   logic        DRAM_RASn;
   logic        DRAM_CASn;
   logic [3:0]  DRAM_WEn;
   logic [10:0] DRAM_A;
   logic [31:0] DRAM_D;
   logic [31:0] DRAM_Q;
   logic        DRAM_valid;
   logic        DRAM_err;

   modport master (
      output DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A, DRAM_D,
      input  DRAM_Q, DRAM_valid, DRAM_err
   );

   modport slave (
      input  DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A, DRAM_D,
      output DRAM_Q, DRAM_valid, DRAM_err
   );
endinterface
`default_nettype wire

// File: rtl/dram_device_model.sv
`default_nettype none
// ============================================================================
// Module      : dram_device_model
// Description : Cycle-accurate single-bank SDRAM-style device model.
//               Decodes ACT/PRE/READ/WRITE from the strobes, keeps one open
//               row, stores 2^(ROW_BITS+COL_BITS) 32-bit words with byte
//               write enables, and returns read data CL cycles after the
//               READ sample edge through a fully pipelined read path.
// Ports       : clk   - single clock, all logic on the rising edge
//               rst_n - asynchronous active-low reset
//               dram  - dram_device_model_if.slave (command, data, status)
// Parameters  : ROW_BITS (11), COL_BITS (10), TRCD (5), TRP (5), CL (5)
// Build option: DRAM_TIMING_CHECK_EN - when defined, illegal commands,
//               ACT with a row open, READ/WRITE with no row open, tRCD and
//               tRP violations raise the sticky DRAM_err and are dropped.
//               When undefined DRAM_err is tied low and every decoded
//               command is executed as-is.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_device_model #(
   parameter int ROW_BITS = 11,
   parameter int COL_BITS = 10,
   parameter int TRCD     = 5,
   parameter int TRP      = 5,
   parameter int CL       = 5
) (
   input logic                clk,
   input logic                rst_n,
   dram_device_model_if.slave dram
);

   localparam int c_ADDR_BITS = ROW_BITS + COL_BITS;
   localparam int c_DEPTH     = 1 << c_ADDR_BITS;
   localparam int c_CNT_MAX   = (TRCD > TRP) ? TRCD : TRP;
   localparam int c_CNT_W     = $clog2(c_CNT_MAX + 2);

   localparam logic [c_CNT_W-1:0] c_TRCD_CNT = c_CNT_W'(TRCD);
   localparam logic [c_CNT_W-1:0] c_TRP_CNT  = c_CNT_W'(TRP);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   // Value loaded on the command edge: the counter then reads "cycles since
   // the command" at every following edge. A zero timing parameter keeps the
   // counter pinned at zero so it never exceeds its saturation value.
   localparam logic [c_CNT_W-1:0] c_ACT_RESTART = (TRCD > 0) ? c_CNT_ONE : '0;
   localparam logic [c_CNT_W-1:0] c_PRE_RESTART = (TRP  > 0) ? c_CNT_ONE : '0;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ROW_BITS-1:0]   r_row;
   logic [c_CNT_W-1:0]    r_act_cnt;
   logic [c_CNT_W-1:0]    r_pre_cnt;
   logic [31:0]           r_mem [c_DEPTH];
   logic [CL-1:0]         r_pipe_vld;
   logic [31:0]           r_pipe_dat [CL];
   logic                  r_valid;
   logic [31:0]           r_q;

   // ------------------------------------------------------------------------
   // Command decode
   // ------------------------------------------------------------------------
   logic w_sel;
   logic w_we_none;
   logic w_we_all;
   logic w_is_act;
   logic w_is_pre;
   logic w_is_rd;
   logic w_is_wr;

   assign w_sel     = ~dram.DRAM_CSn;
   assign w_we_none = (dram.DRAM_WEn == 4'b1111);
   assign w_we_all  = (dram.DRAM_WEn == 4'b0000);
   assign w_is_act  = w_sel & ~dram.DRAM_RASn &  dram.DRAM_CASn & w_we_none;
   assign w_is_pre  = w_sel & ~dram.DRAM_RASn &  dram.DRAM_CASn & w_we_all;
   assign w_is_rd   = w_sel &  dram.DRAM_RASn & ~dram.DRAM_CASn & w_we_none;
   assign w_is_wr   = w_sel &  dram.DRAM_RASn & ~dram.DRAM_CASn & ~w_we_none;

   // Commands that are actually executed this edge.
   logic w_act_ok;
   logic w_rd_ok;
   logic w_wr_ok;

`ifdef DRAM_TIMING_CHECK_EN
   logic w_is_ill;
   logic w_trcd_met;
   logic w_trp_met;
   logic w_err_evt;
   logic r_err;

   // Anything with RASn low that is neither ACT nor PRE is undefined.
   assign w_is_ill   = w_sel & ~dram.DRAM_RASn &
                       ~(dram.DRAM_CASn & (w_we_none | w_we_all));
   assign w_trcd_met = (r_act_cnt >= c_TRCD_CNT);
   assign w_trp_met  = (r_pre_cnt >= c_TRP_CNT);

   assign w_act_ok = w_is_act & (r_state == ST_IDLE)   & w_trp_met;
   assign w_rd_ok  = w_is_rd  & (r_state == ST_ACTIVE) & w_trcd_met;
   assign w_wr_ok  = w_is_wr  & (r_state == ST_ACTIVE) & w_trcd_met;

   assign w_err_evt = w_is_ill | (w_is_act & ~w_act_ok) |
                      (w_is_rd & ~w_rd_ok) | (w_is_wr & ~w_wr_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_err_evt) begin
         r_err <= 1'b1;
      end
   end

   assign dram.DRAM_err = r_err;
`else
   assign w_act_ok = w_is_act;
   assign w_rd_ok  = w_is_rd;
   assign w_wr_ok  = w_is_wr;

   assign dram.DRAM_err = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Bank state machine
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_act_ok) begin
               w_state_nxt = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            // An accepted ACT in ACTIVE only re-latches the row.
            if (w_is_pre) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // The row register survives PRE so that, without checking, a column
   // command in IDLE still addresses the last opened row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row <= '0;
      end else if (w_act_ok) begin
         r_row <= dram.DRAM_A[ROW_BITS-1:0];
      end
   end

   // ------------------------------------------------------------------------
   // tRCD / tRP counters: saturate at their parameter so reset leaves no
   // timing debt and a long idle period never wraps.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_act_cnt <= c_TRCD_CNT;
         r_pre_cnt <= c_TRP_CNT;
      end else begin
         if (w_act_ok) begin
            r_act_cnt <= c_ACT_RESTART;
         end else if (r_act_cnt < c_TRCD_CNT) begin
            r_act_cnt <= r_act_cnt + c_CNT_ONE;
         end

         if (w_is_pre) begin
            r_pre_cnt <= c_PRE_RESTART;
         end else if (r_pre_cnt < c_TRP_CNT) begin
            r_pre_cnt <= r_pre_cnt + c_CNT_ONE;
         end
      end
   end

   a_cnt_saturate : assert property (@(posedge clk) disable iff (!rst_n)
      (r_act_cnt <= c_TRCD_CNT) && (r_pre_cnt <= c_TRP_CNT));

   // ------------------------------------------------------------------------
   // Storage (not reset)
   // ------------------------------------------------------------------------
   logic [COL_BITS-1:0]    w_col;
   logic [c_ADDR_BITS-1:0] w_addr;

   assign w_col  = dram.DRAM_A[COL_BITS-1:0];
   assign w_addr = {r_row, w_col};

   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         for (int i = 0; i < 4; i++) begin
            if (!dram.DRAM_WEn[i]) begin
               r_mem[w_addr][8*i +: 8] <= dram.DRAM_D[8*i +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Read pipeline. The word is captured at the READ edge, so a later WRITE
   // to the same address cannot disturb it. Stage 0 is loaded at the sample
   // edge and the output register one edge after the last stage, giving
   // DRAM_valid exactly CL edges after the READ. Data stages carry zero for
   // empty slots, which keeps DRAM_Q at zero whenever DRAM_valid is low.
   // PRE does not touch this path, so in-flight reads always complete.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pipe_vld <= '0;
         for (int i = 0; i < CL; i++) begin
            r_pipe_dat[i] <= 32'd0;
         end
         r_valid <= 1'b0;
         r_q     <= 32'd0;
      end else begin
         r_pipe_vld[0] <= w_rd_ok;
         r_pipe_dat[0] <= w_rd_ok ? r_mem[w_addr] : 32'd0;
         for (int i = 1; i < CL; i++) begin
            r_pipe_vld[i] <= r_pipe_vld[i-1];
            r_pipe_dat[i] <= r_pipe_dat[i-1];
         end
         r_valid <= r_pipe_vld[CL-1];
         r_q     <= r_pipe_dat[CL-1];
      end
   end

   assign dram.DRAM_valid = r_valid;
   assign dram.DRAM_Q     = r_q;

endmodule
`default_nettype wire

// File: doc/dram_device_model.md
DRAM_DEVICE_MODEL -- requirements
Module: dram_device_model

Interface
REQ-001 SHALL have parameter ROW_BITS, default 11, row address width (A[ROW_BITS-1:0] on activate).
REQ-002 SHALL have parameter COL_BITS, default 10, column address width (A[COL_BITS-1:0] on column command).
REQ-003 SHALL have parameter TRCD, default 5, minimum cycles from ACT to READ/WRITE.
REQ-004 SHALL have parameter TRP, default 5, minimum cycles from PRE to ACT.
REQ-005 SHALL have parameter CL, default 5, cycles from READ sample edge to DRAM_valid.
REQ-006 SHALL have clk, input, 1, single clock; all logic on rising edge.
REQ-007 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have DRAM_CSn, input, 1, chip select, active low.
REQ-009 SHALL have DRAM_RASn, input, 1, row strobe, active low.
REQ-010 SHALL have DRAM_CASn, input, 1, column strobe, active low.
REQ-011 SHALL have DRAM_WEn, input, 4, per-byte write enable, active low.
REQ-012 SHALL have DRAM_A, input, 11, row or column address.
REQ-013 SHALL have DRAM_D, input, 32, write data.
REQ-014 SHALL have DRAM_Q, output, 32, read data.
REQ-015 SHALL have DRAM_valid, output, 1, one-cycle strobe qualifying DRAM_Q.
REQ-016 SHALL have DRAM_err, output, 1, sticky protocol/timing error flag.

Function
REQ-017 Commands SHALL be sampled on rising clk only when DRAM_CSn=0; CSn=1 is NOP.
REQ-018 Decode: RASn=0,CASn=1,WEn=4'b1111 ACT; RASn=0,CASn=1,WEn=4'b0000 PRE; RASn=1,CASn=0,WEn=4'b1111 READ; RASn=1,CASn=0,WEn!=4'b1111 WRITE; RASn=1,CASn=1 NOP; any other combination ILLEGAL.
REQ-019 Bank state machine SHALL have states IDLE (no open row) and ACTIVE (row open): ACT in IDLE latches row=A[ROW_BITS-1:0] -> ACTIVE; PRE -> IDLE; PRE in IDLE is a legal NOP.
REQ-020 Storage SHALL be 2^(ROW_BITS+COL_BITS) x 32-bit words indexed {row, A[COL_BITS-1:0]}; contents are not reset.
REQ-021 WRITE SHALL update byte i of the addressed word with DRAM_D[8i+7:8i] for each i where DRAM_WEn[i]=0, visible to a READ on the next edge.
REQ-022 READ SHALL capture the addressed word at its sample edge and present it on DRAM_Q with DRAM_valid=1 exactly CL cycles later, for one cycle.
REQ-023 Read pipeline SHALL accept one READ per cycle; back-to-back READs yield back-to-back valid beats in issue order.
REQ-024 DRAM_Q SHALL be 32'd0 whenever DRAM_valid=0; both outputs registered.
REQ-025 A WRITE followed by READ of same word on the next cycle SHALL return the new data; a WRITE after a READ SHALL not alter that READ's data.
REQ-026 A saturating cycle counter since last ACT and one since last PRE SHALL track TRCD/TRP (saturate at max parameter, no wrap).
REQ-027 PRE SHALL not cancel READs already in the pipeline.

Reset
REQ-028 On rst_n=0, asynchronously: bank IDLE, read pipeline cleared, DRAM_valid=0, DRAM_Q=0, DRAM_err=0, timing counters saturated (no timing debt).
REQ-029 Reset mid-read SHALL drop all pending beats; no DRAM_valid after release for reads issued before reset.

Configuration
REQ-030 Macro DRAM_TIMING_CHECK_EN defined: ILLEGAL, ACT in ACTIVE, READ/WRITE in IDLE, READ/WRITE < TRCD cycles after ACT, and ACT < TRP cycles after PRE SHALL set DRAM_err (sticky until reset) and be ignored (no state/memory/pipeline change).
REQ-031 Macro undefined: DRAM_err SHALL be tied 0; ACT in ACTIVE re-latches row; READ/WRITE in IDLE use last latched row (0 after reset); timing not checked; ILLEGAL treated as NOP.

Verification
REQ-032 ACT row 0x005 at t, WRITE col 0x010 WEn=0000 D=0xDEADBEEF at t+5, READ col 0x010 at t+6 -> DRAM_valid at t+11 with DRAM_Q=0xDEADBEEF, DRAM_err=0.
REQ-033 Over word 0xDEADBEEF, WRITE WEn=4'b1100 D=0x00001234, then READ -> DRAM_Q=0xDEAD1234.
REQ-034 Four consecutive READs cols 0..3 holding 0x0,0x1,0x2,0x3 -> four consecutive valid beats 0x0,0x1,0x2,0x3 starting CL cycles after first READ.
REQ-035 With DRAM_TIMING_CHECK_EN: ACT at t, READ at t+3 -> DRAM_err=1 next cycle, no DRAM_valid; without macro same stimulus -> valid beat at t+8, DRAM_err=0.
REQ-036 READ issued, rst_n pulsed low 2 cycles later -> DRAM_valid never asserts; bank IDLE; DRAM_err=0.
REQ-037 PRE at t, ACT at t+4 under DRAM_TIMING_CHECK_EN -> DRAM_err=1, bank stays IDLE; ACT at t+5 accepted.
